// File: rtl/wgt_load_ctrl.sv
// wgt_load_ctrl: fills the 3-tap weight shift buffer from the weight SRAM one
// kernel row at a time. Each job walks num_filt filters x KH rows x KW taps
// starting at base_addr, and every completed row is offered to the PE array
// with a valid/ready handshake before the next row is fetched.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset (aborts a job)
//   start                begin a job (sampled only in IDLE)
//   base_addr, num_filt  job parameters, sampled with start (num_filt may be 0)
//   busy                 high in FETCH / DRAIN / PRESENT
//   done                 one-cycle pulse at job end
//   mem_rd_en, mem_addr  weight SRAM read strobe / address
//   mem_rd_data          SRAM data, valid one cycle after mem_rd_en
//   wgt_input, wgt_read  tap and shift enable towards the weight buffer
//   row_valid, row_ready row handshake with the PE array
//   row_idx, filt_idx    kernel row / filter of the presented row
module wgt_load_ctrl #(
  parameter int ADDR_W = 10,
  parameter int KW     = 3,
  parameter int KH     = 3,
  parameter int NF_W   = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [NF_W-1:0]          num_filt,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic signed [7:0]        mem_rd_data,
  output logic signed [7:0]        wgt_input,
  output logic                     wgt_read,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic [1:0]               row_idx,
  output logic [NF_W-1:0]          filt_idx
);

  localparam int TAP_W = (KW > 1) ? $clog2(KW) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [NF_W-1:0]     nf_q;
  logic [NF_W-1:0]     filt_q;
  logic [1:0]          row_q;
  logic [TAP_W-1:0]    tap_q;
  logic                rd_en_q;

  logic last_tap;
  logic last_row;
  logic last_filt;

  assign last_tap  = (tap_q == TAP_W'(KW - 1));
  assign last_row  = (row_q == 2'(KH - 1));
  assign last_filt = (filt_q == (nf_q - NF_W'(1)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (num_filt == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        if (last_tap) state_nxt = S_DRAIN;
      end
      S_DRAIN:   state_nxt = S_PRESENT;
      S_PRESENT: begin
        if (row_ready) state_nxt = (last_row && last_filt) ? S_DONE : S_FETCH;
      end
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    row_valid = 1'b0;
    case (state)
      S_FETCH: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
      end
      S_DRAIN:   busy = 1'b1;
      S_PRESENT: begin
        busy      = 1'b1;
        row_valid = 1'b1;
      end
      S_DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Job counters. The address runs continuously across rows and filters and
  // wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      nf_q    <= '0;
      filt_q  <= '0;
      row_q   <= '0;
      tap_q   <= '0;
      rd_en_q <= 1'b0;
    end else begin
      // SRAM data arrives one cycle after the strobe, so the buffer shift
      // follows the read strobe by one register stage.
      rd_en_q <= (state == S_FETCH);
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q <= base_addr;
            nf_q   <= num_filt;
            filt_q <= '0;
            row_q  <= '0;
            tap_q  <= '0;
          end
        end
        S_FETCH: begin
          addr_q <= addr_q + ADDR_W'(1);
          tap_q  <= last_tap ? '0 : tap_q + TAP_W'(1);
        end
        S_PRESENT: begin
          if (row_ready && !(last_row && last_filt)) begin
            if (last_row) begin
              row_q  <= '0;
              filt_q <= filt_q + NF_W'(1);
            end else begin
              row_q  <= row_q + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign wgt_read  = rd_en_q;
  assign wgt_input = mem_rd_data;
  assign row_idx   = row_q;
  assign filt_idx  = filt_q;

endmodule

// File: tb/tb_wgt_load_ctrl.sv
// Testbench for wgt_load_ctrl. Each job is turned into an expected cycle
// timeline (reads, shifts, row presentation, done) from the row-level timing
// rules, with a weight SRAM and a 3-slot shift buffer modelled alongside.
module tb_wgt_load_ctrl;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [9:0]        base_addr;
  logic [5:0]        num_filt;
  logic              busy, done, mem_rd_en, wgt_read, row_valid, row_ready;
  logic [9:0]        mem_addr;
  logic signed [7:0] mem_rd_data;
  logic signed [7:0] wgt_input;
  logic [1:0]        row_idx;
  logic [5:0]        filt_idx;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [1024];
  logic [7:0] wbuf [3];

  bit e_rd [512];
  bit e_wr [512];
  bit e_valid [512];
  bit e_busy [512];
  bit e_done [512];
  bit e_rdy [512];
  int e_addr [512];
  int e_row [512];
  int e_filt [512];
  int e_rowbase [512];

  wgt_load_ctrl #(.ADDR_W(10), .KW(3), .KH(3), .NF_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_filt(num_filt), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .wgt_input(wgt_input),
    .wgt_read(wgt_read), .row_valid(row_valid), .row_ready(row_ready),
    .row_idx(row_idx), .filt_idx(filt_idx)
  );

  always #5 clk = ~clk;

  // Weight SRAM: one-cycle read latency
  initial mem_rd_data = '0;
  always_ff @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  // Weight shift buffer: new tap enters slot 0, oldest ends in slot 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbuf[0] <= '0; wbuf[1] <= '0; wbuf[2] <= '0;
    end else if (wgt_read) begin
      wbuf[2] <= wbuf[1];
      wbuf[1] <= wbuf[0];
      wbuf[0] <= wgt_input;
    end
  end

  task automatic run_job(input int base, input int nf, input int smin,
                         input int smax, input bit noise, input string name);
    int s, stl, done_c, len;
    for (int i = 0; i < 512; i++) begin
      e_rd[i] = 0; e_wr[i] = 0; e_valid[i] = 0; e_busy[i] = 0; e_done[i] = 0;
      e_rdy[i] = 0; e_addr[i] = 0; e_row[i] = 0; e_filt[i] = 0; e_rowbase[i] = 0;
    end
    // Row r: 3 reads, a drain cycle, then presentation held for its stall time
    s = 1;
    for (int r = 0; r < 3 * nf; r++) begin
      stl = $urandom_range(smax, smin);
      for (int k = 0; k < 3; k++) begin
        e_rd[s + k]     = 1;
        e_addr[s + k]   = (base + 3 * r + k) % 1024;
        e_wr[s + k + 1] = 1;
      end
      for (int k = 0; k <= 4 + stl; k++) e_busy[s + k] = 1;
      for (int k = 0; k <= stl; k++) begin
        e_valid[s + 4 + k]   = 1;
        e_rdy[s + 4 + k]     = (k == stl);
        e_row[s + 4 + k]     = r % 3;
        e_filt[s + 4 + k]    = r / 3;
        e_rowbase[s + 4 + k] = (base + 3 * r) % 1024;
      end
      s += 5 + stl;
    end
    done_c = s;
    e_done[done_c] = 1;
    len = done_c + 3;

    for (int c = 0; c <= len; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        start = 1'b1; base_addr = 10'(base); num_filt = 6'(nf);
        row_ready = 1'($urandom_range(1, 0));
      end else begin
        start = (noise && c <= done_c) ? 1'($urandom_range(1, 0)) : 1'b0;
        if (noise) begin
          base_addr = 10'($urandom); num_filt = 6'($urandom);
        end
        row_ready = e_valid[c] ? e_rdy[c] : 1'($urandom_range(1, 0));
      end
      @(negedge clk);
      checks++;
      if (mem_rd_en !== e_rd[c]) begin
        errors++; $display("FAIL %s c%0d mem_rd_en got %b exp %b", name, c, mem_rd_en, e_rd[c]);
      end
      if (e_rd[c]) begin
        checks++;
        if (mem_addr !== 10'(e_addr[c])) begin
          errors++; $display("FAIL %s c%0d mem_addr got %h exp %h", name, c, mem_addr, e_addr[c]);
        end
      end
      checks++;
      if (wgt_read !== e_wr[c]) begin
        errors++; $display("FAIL %s c%0d wgt_read got %b exp %b", name, c, wgt_read, e_wr[c]);
      end
      checks++;
      if (row_valid !== e_valid[c]) begin
        errors++; $display("FAIL %s c%0d row_valid got %b exp %b", name, c, row_valid, e_valid[c]);
      end
      checks++;
      if (busy !== e_busy[c]) begin
        errors++; $display("FAIL %s c%0d busy got %b exp %b", name, c, busy, e_busy[c]);
      end
      checks++;
      if (done !== e_done[c]) begin
        errors++; $display("FAIL %s c%0d done got %b exp %b", name, c, done, e_done[c]);
      end
      checks++;
      if (wgt_input !== mem_rd_data) begin
        errors++; $display("FAIL %s c%0d wgt_input got %h exp %h", name, c, wgt_input, mem_rd_data);
      end
      if (e_valid[c]) begin
        checks++;
        if (row_idx !== 2'(e_row[c]) || filt_idx !== 6'(e_filt[c])) begin
          errors++;
          $display("FAIL %s c%0d row/filt got %0d/%0d exp %0d/%0d", name, c,
                   row_idx, filt_idx, e_row[c], e_filt[c]);
        end
        checks++;
        if (wbuf[2] !== mem[e_rowbase[c]] || wbuf[1] !== mem[(e_rowbase[c] + 1) % 1024] ||
            wbuf[0] !== mem[(e_rowbase[c] + 2) % 1024]) begin
          errors++;
          $display("FAIL %s c%0d buffer got %h %h %h exp %h %h %h", name, c,
                   wbuf[2], wbuf[1], wbuf[0], mem[e_rowbase[c]],
                   mem[(e_rowbase[c] + 1) % 1024], mem[(e_rowbase[c] + 2) % 1024]);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({busy, done, mem_rd_en, wgt_read, row_valid} !== 5'b0 ||
        mem_addr !== 10'd0 || row_idx !== 2'd0 || filt_idx !== 6'd0) begin
      errors++;
      $display("FAIL %s outputs got busy%b done%b rd%b wr%b val%b addr%h row%0d filt%0d exp all 0",
               name, busy, done, mem_rd_en, wgt_read, row_valid, mem_addr, row_idx, filt_idx);
    end
    checks++;
    if (wbuf[0] !== 8'd0 || wbuf[1] !== 8'd0 || wbuf[2] !== 8'd0) begin
      errors++;
      $display("FAIL %s buffer got %h %h %h exp 00 00 00", name, wbuf[2], wbuf[1], wbuf[0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_filt = '0; row_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int a = 0; a < 1024; a++) mem[a] = 8'(a);
    run_job(16'h010, 1, 0, 0, 0, "basic");
  endtask

  task automatic test_backpressure();
    for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom);
    run_job(int'($urandom_range(1023, 0)), 1, 7, 7, 0, "backpressure");
  endtask

  task automatic test_two_filters();
    run_job(int'($urandom_range(1023, 0)), 2, 0, 0, 0, "two_filt");
  endtask

  task automatic test_wrap();
    run_job(16'h3FE, 1, 0, 0, 0, "wrap");
  endtask

  task automatic test_zero_filt();
    run_job(int'($urandom_range(1023, 0)), 0, 0, 0, 0, "zero_filt");
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 4; j++)
      run_job(int'($urandom_range(1023, 0)), int'($urandom_range(3, 1)), 0, 4, 1, "random");
  endtask

  task automatic test_reset_abort();
    @(posedge clk);
    #1 start = 1'b1; base_addr = 10'h155; num_filt = 6'd2; row_ready = 1'b1;
    // Second row fetch spans cycles 6..8; abort in cycle 7
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 10'h159) begin
      errors++;
      $display("FAIL abort pre rd %b addr %h exp 1 159", mem_rd_en, mem_addr);
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL abort_hold done %b busy %b exp 0 0", done, busy);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_job(int'($urandom_range(1023, 0)), 1, 0, 2, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_job(int'($urandom_range(1023, 0)), 1, 0, 0, 0, "b2b_a");
    run_job(int'($urandom_range(1023, 0)), 3, 0, 1, 0, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_two_filters();
    test_wrap();
    test_zero_filt();
    test_random_jobs();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wgt_load_ctrl.md
Name: wgt_load_ctrl

Overview:
Sequencer that fills the 3-tap weight shift buffer from the weight SRAM, one kernel row at a time. On start it walks num_filt filters × KH rows × KW taps from base_addr. Each row's taps are shifted into the buffer via wgt_read/wgt_input. The full row is then presented to the PE array with a valid/ready handshake before the next row is fetched. It sits between the weight SRAM, the weight buffer and the convolution top-level controller.

Parameters:
ADDR_W, 10, weight SRAM address width
KW, 3, taps per kernel row (must equal the buffer depth)
KH, 3, rows per kernel
NF_W, 6, width of num_filt and filt_idx

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin a load job; sampled only in IDLE
base_addr  in  ADDR_W  first SRAM address of the job; sampled with start
num_filt  in  NF_W  filters to load; sampled with start; 0 allowed
busy  out  1  high in FETCH/DRAIN/PRESENT
done  out  1  one-cycle pulse at job end
mem_rd_en  out  1  SRAM read strobe
mem_addr  out  ADDR_W  SRAM read address
mem_rd_data  in  8  signed; valid exactly 1 cycle after mem_rd_en
wgt_input  out  8  signed tap to buffer; combinationally equal to mem_rd_data
wgt_read  out  1  buffer shift enable
row_valid  out  1  buffer holds a complete row
row_ready  in  1  PE array has consumed the row
row_idx  out  2  kernel row of the presented row (0..KH-1)
filt_idx  out  NF_W  filter of the presented row

Behaviour:
- Reset values: all outputs 0; state IDLE; address, tap, row and filter counters 0.
- rst_n asserted at any time aborts the job immediately. No done pulse is produced, and the weight buffer is cleared by the same reset.
- States: IDLE, FETCH, DRAIN, PRESENT, DONE.
- IDLE, start=1, num_filt≠0: latch base_addr and num_filt; go to FETCH.
- IDLE, start=1, num_filt=0: go to DONE; no reads are issued.
- FETCH (KW cycles): mem_rd_en=1 every cycle. mem_addr starts at base_addr and increments by 1 per read across the whole job. Address wraps modulo 2^ADDR_W. After KW reads, go to DRAIN.
- wgt_read is mem_rd_en delayed by one register stage. The final shift of a row therefore occurs in the DRAIN cycle.
- DRAIN (1 cycle): go to PRESENT.
- PRESENT: row_valid=1, with row_idx and filt_idx stable. Hold in PRESENT until row_valid & row_ready.
- On the handshake cycle:
  - not the last row: increment row_idx (wrap to 0 and increment filt_idx after KH-1), then go to FETCH;
  - last row of the last filter: go to DONE.
- DONE (1 cycle): done=1, busy=0; then go to IDLE.
- start is ignored in every state except IDLE, including DONE.
- row_ready outside PRESENT is ignored. wgt_read is never asserted in PRESENT, so the presented row is held stable.
- Timing, with start sampled in cycle t:
  - mem_rd_en in t+1..t+3;
  - wgt_read in t+2..t+4;
  - row_valid from t+5.
- With row_ready held high, each row takes 5 cycles (FETCH 3, DRAIN 1, PRESENT 1).
- Tap order: the first-read tap ends in buffer slot 2 and the last-read tap in slot 0.

Test Plan:
- num_filt=1, base_addr=0x010, SRAM[a]=a[7:0], row_ready=1 → mem_addr 0x010..0x018 in three bursts of 3. row_valid in cycles t+5, t+10 and t+15 with row_idx 0,1,2. Buffer slots (2,1,0) = (0x10,0x11,0x12), then (0x13,0x14,0x15), then (0x16,0x17,0x18). done in t+16.
- Backpressure: row_ready=0 for 7 cycles in each PRESENT → row_valid held, no mem_rd_en or wgt_read, buffer contents unchanged. The job resumes one cycle after row_ready rises.
- num_filt=2, row_ready=1 → 18 reads. filt_idx is 0 for rows 0-2 and 1 for rows 3-5. A single done pulse, 31 cycles after start.
- Wrap: base_addr=0x3FE, num_filt=1 → first row reads addresses 0x3FE, 0x3FF, 0x000.
- num_filt=0 → done in t+1; mem_rd_en never asserted; busy stays 0.
- Pulse start mid-job → ignored. Assert rst_n low during the second FETCH → all outputs 0 immediately and no done. A new start after reset runs normally from the new base_addr.
